// File: rtl/issue_unit.sv
// Issue scheduler for the int, load/store, multiply and divide queues: picks one ready head per
// cycle in least-recently-issued order and reserves the CDB slot its result will return in.
module issue_unit #(
  parameter int INT_LAT   = 1,
  parameter int LD_ST_LAT = 2,
  parameter int MULT_LAT  = 4,
  parameter int DIV_LAT   = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_int_ready,
  input  logic       i_ld_st_ready,
  input  logic       i_mult_ready,
  input  logic       i_div_ready,
  output logic       o_int_rd,
  output logic       o_ld_st_rd,
  output logic       o_mult_rd,
  output logic       o_div_rd,
  output logic [1:0] o_cdb_sel,
  output logic       o_cdb_sel_valid,
  output logic       o_div_busy
);

  generate
    if (!(1 <= INT_LAT && INT_LAT < LD_ST_LAT && LD_ST_LAT < MULT_LAT &&
          MULT_LAT < DIV_LAT && DIV_LAT <= 32)) begin : g_bad_latency
      $error("issue_unit: latencies must satisfy 1 <= INT < LD_ST < MULT < DIV <= 32");
    end
  endgenerate

  localparam int IDX_W = $clog2(DIV_LAT);

  localparam logic [1:0] U_INT   = 2'd0;
  localparam logic [1:0] U_LD_ST = 2'd1;
  localparam logic [1:0] U_MULT  = 2'd2;
  localparam logic [1:0] U_DIV   = 2'd3;

  logic [DIV_LAT-1:0] slot_valid;
  logic [1:0]         slot_owner [DIV_LAT];
  logic [DIV_LAT:0]   slot_taken;
  logic [1:0]         lru [4];
  logic [1:0]         lru_next [4];
  logic [4:0]         div_cnt;
  logic [3:0]         ready;
  logic [3:0]         eligible;
  logic [3:0]         rd;
  logic               issue;
  logic [1:0]         winner;
  int                 win_pos;
  logic [IDX_W-1:0]   wr_idx;

  // Slot DIV_LAT lies beyond the table and always reads free.
  assign slot_taken = {1'b0, slot_valid};
  assign ready      = {i_div_ready, i_mult_ready, i_ld_st_ready, i_int_ready};

  assign eligible[U_INT]   = ready[U_INT]   & ~slot_taken[INT_LAT];
  assign eligible[U_LD_ST] = ready[U_LD_ST] & ~slot_taken[LD_ST_LAT];
  assign eligible[U_MULT]  = ready[U_MULT]  & ~slot_taken[MULT_LAT];
  assign eligible[U_DIV]   = ready[U_DIV]   & ~slot_taken[DIV_LAT] & ~o_div_busy;

  always_comb begin
    issue   = 1'b0;
    winner  = U_INT;
    win_pos = 0;
    for (int i = 0; i < 4; i++) begin
      if (!issue && eligible[lru[i]]) begin
        issue   = 1'b1;
        winner  = lru[i];
        win_pos = i;
      end
    end
    if (i_rst) issue = 1'b0;
  end

  always_comb begin
    rd = 4'b0000;
    if (issue) rd[winner] = 1'b1;
  end

  assign o_int_rd   = rd[U_INT];
  assign o_ld_st_rd = rd[U_LD_ST];
  assign o_mult_rd  = rd[U_MULT];
  assign o_div_rd   = rd[U_DIV];

  // The winner leaves its place and rejoins at the tail; everyone behind it moves up.
  always_comb begin
    for (int i = 0; i < 4; i++) lru_next[i] = lru[i];
    if (issue) begin
      for (int i = 0; i < 3; i++) begin
        if (i >= win_pos) lru_next[i] = lru[i+1];
      end
      lru_next[3] = winner;
    end
  end

  always_comb begin
    case (winner)
      U_INT:   wr_idx = IDX_W'(INT_LAT - 1);
      U_LD_ST: wr_idx = IDX_W'(LD_ST_LAT - 1);
      U_MULT:  wr_idx = IDX_W'(MULT_LAT - 1);
      default: wr_idx = IDX_W'(DIV_LAT - 1);
    endcase
  end

  // The table shifts one slot toward the CDB each edge; a new issue lands one slot short of
  // its latency because that shift is already applied.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot_valid <= '0;
      for (int k = 0; k < DIV_LAT; k++) slot_owner[k] <= U_INT;
      lru[0] <= U_INT;
      lru[1] <= U_LD_ST;
      lru[2] <= U_MULT;
      lru[3] <= U_DIV;
      div_cnt <= 5'd0;
    end else begin
      for (int k = 0; k < DIV_LAT - 1; k++) begin
        slot_valid[k] <= slot_valid[k+1];
        slot_owner[k] <= slot_owner[k+1];
      end
      slot_valid[DIV_LAT-1] <= 1'b0;
      slot_owner[DIV_LAT-1] <= U_INT;
      if (issue) begin
        slot_valid[wr_idx] <= 1'b1;
        slot_owner[wr_idx] <= winner;
      end
      for (int i = 0; i < 4; i++) lru[i] <= lru_next[i];
      if (o_div_rd) div_cnt <= 5'(DIV_LAT - 1);
      else if (div_cnt != 5'd0) div_cnt <= div_cnt - 5'd1;
    end
  end

  assign o_cdb_sel       = slot_owner[0];
  assign o_cdb_sel_valid = slot_valid[0];
  assign o_div_busy      = (div_cnt != 5'd0);

endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: per-cycle strobe expectations and CDB return expectations are
// queued by the stimulus and drained by an independent negedge monitor.
module tb_issue_unit;

  typedef struct {
    logic [3:0] rd;
    logic       busy;
  } strobe_t;

  typedef struct {
    logic [1:0] owner;
    int         cyc;
  } cdb_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       int_ready = 1'b0, ld_st_ready = 1'b0, mult_ready = 1'b0, div_ready = 1'b0;
  logic       int_rd, ld_st_rd, mult_rd, div_rd;
  logic [1:0] cdb_sel;
  logic       cdb_sel_valid;
  logic       div_busy;

  strobe_t strobe_q[$];
  cdb_t    cdb_q[$];
  int      cyc = 0;
  int      base = 0;
  int      vectors = 0;
  int      miscompares = 0;
  logic    mon_on = 1'b0;

  issue_unit dut (
    .i_clk(clk), .i_rst(rst),
    .i_int_ready(int_ready), .i_ld_st_ready(ld_st_ready),
    .i_mult_ready(mult_ready), .i_div_ready(div_ready),
    .o_int_rd(int_rd), .o_ld_st_rd(ld_st_rd), .o_mult_rd(mult_rd), .o_div_rd(div_rd),
    .o_cdb_sel(cdb_sel), .o_cdb_sel_valid(cdb_sel_valid), .o_div_busy(div_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ready and rd vectors are ordered {div, mult, ld_st, int}
  task automatic apply_stimulus(input logic rst_v, input logic [3:0] rdy,
                                input logic [3:0] exp_rd, input logic exp_busy);
    strobe_t s;
    @(posedge clk);
    #1;
    rst = rst_v;
    {div_ready, mult_ready, ld_st_ready, int_ready} = rdy;
    s.rd   = exp_rd;
    s.busy = exp_busy;
    strobe_q.push_back(s);
    mon_on = 1'b1;
  endtask

  task automatic expect_cdb(input logic [1:0] owner, input int rel);
    cdb_t c;
    c.owner = owner;
    c.cyc   = base + rel;
    cdb_q.push_back(c);
  endtask

  task automatic start_test();
    apply_stimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
    base = cyc + 1;
  endtask

  task automatic check_output();
    strobe_t s;
    cdb_t    c;
    logic [3:0] act_rd;
    logic exp_v;
    act_rd = {div_rd, mult_rd, ld_st_rd, int_rd};
    vectors++;
    if (!$onehot0(act_rd)) begin
      miscompares++;
      $display("[TB] FAIL onehot cyc=%0d rd=%b", cyc, act_rd);
    end
    if (strobe_q.size() > 0) begin
      s = strobe_q.pop_front();
      vectors++;
      if (act_rd !== s.rd) begin
        miscompares++;
        $display("[TB] FAIL rd cyc=%0d got=%b want=%b", cyc, act_rd, s.rd);
      end
      vectors++;
      if (div_busy !== s.busy) begin
        miscompares++;
        $display("[TB] FAIL div_busy cyc=%0d got=%b want=%b", cyc, div_busy, s.busy);
      end
    end
    while (cdb_q.size() > 0 && cdb_q[0].cyc < cyc) begin
      c = cdb_q.pop_front();
      vectors++;
      miscompares++;
      $display("[TB] FAIL cdb_missing cyc=%0d got=none want=owner %0d", c.cyc, c.owner);
    end
    exp_v = (cdb_q.size() > 0) && (cdb_q[0].cyc == cyc);
    vectors++;
    if (cdb_sel_valid !== exp_v) begin
      miscompares++;
      $display("[TB] FAIL cdb_valid cyc=%0d got=%b want=%b", cyc, cdb_sel_valid, exp_v);
    end
    if (exp_v) begin
      c = cdb_q.pop_front();
      vectors++;
      if (cdb_sel !== c.owner) begin
        miscompares++;
        $display("[TB] FAIL cdb_sel cyc=%0d got=%0d want=%0d", cyc, cdb_sel, c.owner);
      end
    end
  endtask

  always @(negedge clk) if (mon_on) check_output();

  initial begin
    $display("[TB] issue_unit directed run");

    // Reset held with all readies high, then released with int at the head of the order.
    apply_stimulus(1'b1, 4'b1111, 4'b0000, 1'b0);
    apply_stimulus(1'b1, 4'b1111, 4'b0000, 1'b0);
    base = cyc + 1;
    expect_cdb(2'd0, 1);
    apply_stimulus(1'b0, 4'b1111, 4'b0001, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Integer stream, c0-c4.
    start_test();
    for (int c = 1; c <= 5; c++) expect_cdb(2'd0, c);
    for (int c = 0; c <= 4; c++) apply_stimulus(1'b0, 4'b0001, 4'b0001, 1'b0);
    for (int c = 5; c <= 7; c++) apply_stimulus(1'b0, 4'b0000, 4'b0000, 1'b0);

    // All four ready: LRU order int, ld_st, mult, div.
    start_test();
    expect_cdb(2'd0, 1);
    expect_cdb(2'd1, 3);
    expect_cdb(2'd2, 6);
    expect_cdb(2'd3, 11);
    apply_stimulus(1'b0, 4'b1111, 4'b0001, 1'b0);
    apply_stimulus(1'b0, 4'b1110, 4'b0010, 1'b0);
    apply_stimulus(1'b0, 4'b1100, 4'b0100, 1'b0);
    apply_stimulus(1'b0, 4'b1000, 4'b1000, 1'b0);
    for (int c = 4; c <= 12; c++) apply_stimulus(1'b0, 4'b0000, 4'b0000, c <= 10);

    // Slot conflicts: mult owns c4, ld_st then owns c5, int must wait for c6.
    start_test();
    expect_cdb(2'd2, 4);
    expect_cdb(2'd1, 5);
    expect_cdb(2'd0, 6);
    apply_stimulus(1'b0, 4'b0100, 4'b0100, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
    apply_stimulus(1'b0, 4'b0010, 4'b0000, 1'b0);
    apply_stimulus(1'b0, 4'b0011, 4'b0010, 1'b0);
    apply_stimulus(1'b0, 4'b0001, 4'b0000, 1'b0);
    apply_stimulus(1'b0, 4'b0001, 4'b0001, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Divider occupancy: one issue every 8 cycles.
    start_test();
    expect_cdb(2'd3, 8);
    expect_cdb(2'd3, 16);
    expect_cdb(2'd3, 24);
    for (int c = 0; c <= 16; c++)
      apply_stimulus(1'b0, 4'b1000, (c % 8 == 0) ? 4'b1000 : 4'b0000, (c % 8) != 0);
    for (int c = 17; c <= 25; c++)
      apply_stimulus(1'b0, 4'b0000, 4'b0000, c <= 23);

    // Reset mid-operation discards the mult reservation for c4.
    start_test();
    expect_cdb(2'd0, 7);
    apply_stimulus(1'b0, 4'b0100, 4'b0100, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
    for (int c = 2; c <= 5; c++) apply_stimulus(1'b1, 4'b0001, 4'b0000, 1'b0);
    apply_stimulus(1'b0, 4'b0001, 4'b0001, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 4'b0000, 1'b0);

    @(negedge clk);
    #1;
    while (cdb_q.size() > 0) begin
      cdb_t c;
      c = cdb_q.pop_front();
      vectors++;
      miscompares++;
      $display("[TB] FAIL cdb_never_seen cyc=%0d got=none want=owner %0d", c.cyc, c.owner);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
